// File: rtl/game_pkg.sv
// Shared types and constants for the game controller's countdown timer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_HOLD,
    ST_EXPIRED
  } timer_state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;

  localparam logic [3:0] L2_TENS  = 4'd9;
  localparam logic [3:0] L2_UNITS = 4'd0;
  localparam logic [3:0] L3_TENS  = 4'd6;
  localparam logic [3:0] L3_UNITS = 4'd0;

  // Out-of-range preset digits saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-second terminal-count pulse; count holds while disabled.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_c
);

  localparam logic [DIV_W-1:0] TC_VAL = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Terminal count is only meaningful in a cycle that actually advances.
  assign tc_c = en_i && (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// BCD seconds countdown timer: load/arm/run/hold/expire FSM with a shared one-second prescaler.
module game_countdown_timer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Timer_Load,
  input  logic       Timer_Enable,
  input  logic [3:0] Timer_Tens_Digit,
  input  logic [3:0] Timer_Units_Digit,
  output logic [3:0] Count_Tens,
  output logic [3:0] Count_Units,
  output logic       Timer_TimeOut,
  output logic       Sec_Tick
);

  timer_state_e state_q, state_d;
  logic [3:0]   tens_q, tens_d;
  logic [3:0]   units_q, units_d;
  logic         timeout_q, timeout_d;
  logic         tick_q;

  logic         cnt_en_c;
  logic         tick_c;
  logic [3:0]   ld_tens_c;
  logic [3:0]   ld_units_c;

  // The first enabled cycle out of ARMED/HOLD already advances the prescaler.
  assign cnt_en_c = !Timer_Load && Timer_Enable &&
                    (state_q inside {ST_ARMED, ST_RUN, ST_HOLD});

  assign ld_tens_c  = bcd_clamp(Timer_Tens_Digit);
  assign ld_units_c = bcd_clamp(Timer_Units_Digit);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cnt_en_c),
    .clr_i (Timer_Load),
    .tc_c  (tick_c)
  );

  // Next-state, BCD decrement and timeout level.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;

    if (Timer_Load) begin
      tens_d  = ld_tens_c;
      units_d = ld_units_c;
      state_d = ((ld_tens_c == 4'd0) && (ld_units_c == 4'd0)) ? ST_EXPIRED : ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_ARMED,
        ST_HOLD:    if (Timer_Enable) state_d = ST_RUN;
        ST_RUN:     if (!Timer_Enable) state_d = ST_HOLD;
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase

      if (tick_c) begin
        if (units_q != 4'd0) begin
          units_d = units_q - 4'd1;
        end else if (tens_q != 4'd0) begin
          units_d = BCD_MAX;
          tens_d  = tens_q - 4'd1;
        end
        if ((tens_d == 4'd0) && (units_d == 4'd0)) begin
          state_d = ST_EXPIRED;
        end
      end
    end

    timeout_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tens_q    <= 4'd0;
      units_q   <= 4'd0;
      timeout_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      timeout_q <= timeout_d;
      tick_q    <= tick_c;
    end
  end

  assign Count_Tens    = tens_q;
  assign Count_Units   = units_q;
  assign Timer_TimeOut = timeout_q;
  assign Sec_Tick      = tick_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed vector bench for game_countdown_timer with a 4-cycle second.
module tb_game_countdown_timer;
  import game_pkg::*;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DIV_W    = 3;

  typedef struct packed {
    logic       rst;
    logic       load;
    logic       en;
    logic [3:0] tens_in;
    logic [3:0] units_in;
    logic [3:0] exp_tens;
    logic [3:0] exp_units;
    logic       exp_to;
    logic       exp_tick;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       Timer_Load;
  logic       Timer_Enable;
  logic [3:0] Timer_Tens_Digit;
  logic [3:0] Timer_Units_Digit;
  logic [3:0] Count_Tens;
  logic [3:0] Count_Units;
  logic       Timer_TimeOut;
  logic       Sec_Tick;

  int n_vec = 0;
  int n_err = 0;
  vec_t vq[$];

  game_countdown_timer #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .Timer_Load        (Timer_Load),
    .Timer_Enable      (Timer_Enable),
    .Timer_Tens_Digit  (Timer_Tens_Digit),
    .Timer_Units_Digit (Timer_Units_Digit),
    .Count_Tens        (Count_Tens),
    .Count_Units       (Count_Units),
    .Timer_TimeOut     (Timer_TimeOut),
    .Sec_Tick          (Sec_Tick)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic ld, input logic en,
                       input logic [3:0] t, input logic [3:0] u);
    rst               = r;
    Timer_Load        = ld;
    Timer_Enable      = en;
    Timer_Tens_Digit  = t;
    Timer_Units_Digit = u;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] et, input logic [3:0] eu,
                       input logic eto, input logic etk);
    n_vec++;
    if (Count_Tens !== et || Count_Units !== eu || Timer_TimeOut !== eto || Sec_Tick !== etk) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d%0d to=%b tick=%b, required %0d%0d to=%b tick=%b",
               name, idx, Count_Tens, Count_Units, Timer_TimeOut, Sec_Tick, et, eu, eto, etk);
    end
  endtask

  task automatic add(input logic r, input logic ld, input logic en,
                     input logic [3:0] t, input logic [3:0] u,
                     input logic [3:0] et, input logic [3:0] eu,
                     input logic eto, input logic etk);
    vec_t v;
    v.rst = r; v.load = ld; v.en = en; v.tens_in = t; v.units_in = u;
    v.exp_tens = et; v.exp_units = eu; v.exp_to = eto; v.exp_tick = etk;
    vq.push_back(v);
  endtask

  task automatic run_table(input string name);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].load, vq[i].en, vq[i].tens_in, vq[i].units_in);
      step();
      check(name, i, vq[i].exp_tens, vq[i].exp_units, vq[i].exp_to, vq[i].exp_tick);
    end
    vq.delete();
  endtask

  // Enabled run from a known preset; expected digits come from elapsed seconds.
  task automatic run_enabled(input string name, input int preset_secs,
                             input int first, input int last);
    int secs;
    for (int i = first; i <= last; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      step();
      secs = preset_secs - i / int'(TICK_DIV);
      if (secs < 0) secs = 0;
      check(name, i, 4'(secs / 10), 4'(secs % 10), secs == 0, (i % int'(TICK_DIV)) == 0);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

    // Reset, idle enable, level-2 load and the first second.
    add(1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 1, 1, L2_TENS, L2_UNITS,  9, 0, 0, 0);
    add(0, 0, 1, 0, 0,  9, 0, 0, 0);
    add(0, 0, 1, 0, 0,  9, 0, 0, 0);
    add(0, 0, 1, 0, 0,  9, 0, 0, 0);
    add(0, 0, 1, 0, 0,  8, 9, 0, 1);
    add(0, 0, 1, 0, 0,  8, 9, 0, 0);
    run_table("l2_start");

    // Remaining 355 enabled cycles down to 00, then hold at timeout.
    run_enabled("l2_run", 90, 6, 360);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, (i % 2) == 0, 4'd0, 4'd0);
      step();
      check("expired_hold", i, 0, 0, 1, 0);
    end

    // Reload from EXPIRED with enable high: load wins, arms at 60.
    add(0, 1, 1, L3_TENS, L3_UNITS,  6, 0, 0, 0);
    run_table("reload");

    // Pause/resume keeps prescaler phase.
    run_enabled("l3_run", 60, 1, 10);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      step();
      check("paused", i, 5, 8, 0, 0);
    end
    add(0, 0, 1, 0, 0,  5, 8, 0, 0);
    add(0, 0, 1, 0, 0,  5, 7, 0, 1);
    add(0, 0, 1, 0, 0,  5, 7, 0, 0);
    add(0, 0, 1, 0, 0,  5, 7, 0, 0);
    add(0, 0, 1, 0, 0,  5, 7, 0, 0);
    add(0, 0, 1, 0, 0,  5, 6, 0, 1);
    run_table("resume");

    // Units borrow 10 -> 09, zero load, clamp, mid-run reload.
    add(0, 1, 0, 1, 0,  1, 0, 0, 0);
    add(0, 0, 1, 0, 0,  1, 0, 0, 0);
    add(0, 0, 1, 0, 0,  1, 0, 0, 0);
    add(0, 0, 1, 0, 0,  1, 0, 0, 0);
    add(0, 0, 1, 0, 0,  0, 9, 0, 1);
    add(0, 0, 1, 0, 0,  0, 9, 0, 0);
    add(0, 1, 1, 0, 0,  0, 0, 1, 0);
    add(0, 0, 1, 0, 0,  0, 0, 1, 0);
    add(0, 1, 0, 12, 15,  9, 9, 0, 0);
    add(0, 0, 1, 0, 0,  9, 9, 0, 0);
    add(0, 0, 1, 0, 0,  9, 9, 0, 0);
    add(0, 1, 1, 3, 0,  3, 0, 0, 0);
    add(0, 0, 1, 0, 0,  3, 0, 0, 0);
    add(0, 0, 1, 0, 0,  3, 0, 0, 0);
    add(0, 0, 1, 0, 0,  3, 0, 0, 0);
    add(0, 0, 1, 0, 0,  2, 9, 0, 1);
    run_table("edges");

    // Reset mid-run at 45: count lost, back to IDLE which ignores enable.
    add(0, 1, 0, 4, 6,  4, 6, 0, 0);
    add(0, 0, 1, 0, 0,  4, 6, 0, 0);
    add(0, 0, 1, 0, 0,  4, 6, 0, 0);
    add(0, 0, 1, 0, 0,  4, 6, 0, 0);
    add(0, 0, 1, 0, 0,  4, 5, 0, 1);
    add(0, 0, 1, 0, 0,  4, 5, 0, 0);
    add(0, 0, 1, 0, 0,  4, 5, 0, 0);
    add(0, 0, 1, 0, 0,  4, 5, 0, 0);
    add(1, 0, 1, 0, 0,  0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0,  0, 0, 0, 0);
    run_table("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
